// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges NUM_CH producer FIFOs onto one register-file write port via round-robin
module writeback_arbiter #(
  parameter int CORE = 0,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            ch_valid,
  output logic [NUM_CH-1:0]            ch_ready,
  input  logic [5*NUM_CH-1:0]          ch_reg,
  input  logic [DATA_WIDTH*NUM_CH-1:0] ch_data,
  output logic                         write,
  output logic [4:0]                   write_reg,
  output logic [DATA_WIDTH-1:0]        write_data,
  output logic [$clog2(NUM_CH)-1:0]    grant_ch,
  output logic [31:0]                  reg_pending,
  input  logic                         scan
);
  localparam int GW = $clog2(NUM_CH);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [4:0]            q_reg  [NUM_CH][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]         rd_ptr [NUM_CH];
  logic [AW-1:0]         wr_ptr [NUM_CH];
  logic [AW:0]           count  [NUM_CH];
  logic [NUM_CH-1:0]     push, pop, nonempty;
  logic [GW-1:0]         rr_ptr, gnt, idx;
  logic [AW-1:0]         off;
  logic                  any;
  logic [31:0]           cycles;

  always_comb
    for (int i = 0; i < NUM_CH; i++) begin
      ch_ready[i] = count[i] != (AW+1)'(FIFO_DEPTH);
      nonempty[i] = count[i] != '0;
      push[i] = ch_valid[i] & ch_ready[i] & (ch_reg[5*i +: 5] != 5'd0);
    end

  // scan from farthest to nearest so the channel closest after rr_ptr wins
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = GW'((int'(rr_ptr) + k) % NUM_CH);
      if (nonempty[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
    pop = '0;
    pop[gnt] = any;
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset)
      for (int i = 0; i < NUM_CH; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i] <= '0;
      end
    else
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= count[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
      end

  always_ff @(posedge clock)
    for (int i = 0; i < NUM_CH; i++)
      if (push[i]) begin
        q_reg[i][wr_ptr[i]] <= ch_reg[5*i +: 5];
        q_data[i][wr_ptr[i]] <= ch_data[DATA_WIDTH*i +: DATA_WIDTH];
      end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      write <= 1'b0;
      write_reg <= '0;
      write_data <= '0;
      grant_ch <= '0;
      rr_ptr <= GW'(NUM_CH - 1);
      cycles <= '0;
    end else begin
      cycles <= cycles + 1'b1;
      write <= any;
      if (any) begin
        write_reg <= q_reg[gnt][rd_ptr[gnt]];
        write_data <= q_data[gnt][rd_ptr[gnt]];
        grant_ch <= gnt;
        rr_ptr <= gnt;
      end
    end

  always_comb begin
    reg_pending = '0;
    off = '0;
    for (int i = 0; i < NUM_CH; i++)
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        off = AW'(j) - rd_ptr[i];
        if ({1'b0, off} < count[i]) reg_pending[q_reg[i][j]] = 1'b1;
      end
    if (write) reg_pending[write_reg] = 1'b1;
    reg_pending[0] = 1'b0;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock)
    if (scan && cycles >= 32'(SCAN_CYCLES_MIN) && cycles <= 32'(SCAN_CYCLES_MAX)) begin
      $display("core %0d cycle %0d grant_ch %0d write %b write_reg %0d write_data %h",
               CORE, cycles, grant_ch, write, write_reg, write_data);
      for (int i = 0; i < NUM_CH; i++)
        $display("core %0d ch%0d valid %b ready %b occ %0d", CORE, i, ch_valid[i], ch_ready[i], count[i]);
    end
`endif
endmodule
